lsu_axi_ctrl: RTL and testbench

Parametrised load/store unit with an AXI-lite master port, sitting between EXU and WBU. It runs one outstanding memory request at a time through a valid/ready request interface. It does byte-lane alignment (wstrb/wdata shift, load extract plus sign/zero-extension), detects misaligned accesses, reports bus errors, and handles independent AW/W handshakes. Supports a 32- or 64-bit data path.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_axi_ctrl_if.sv | 39 +++
 rtl/lsu_lane_align.sv | 63 ++++++
 rtl/lsu_axi_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_lsu_axi_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 encodings and helpers for the load/store unit
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR,
    S_WR_RESP,
    S_RESP
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] AXI_OKAY = 2'b00;

  // Byte-enable pattern for an access of the size encoded in funct3[1:0], unshifted.
  function automatic logic [7:0] size_mask(input logic [2:0] func3);
    logic [7:0] m;
    case (func3[1:0])
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_axi_ctrl_if.sv
// rtl/lsu_axi_ctrl_if.sv - AXI-lite bundle between the load/store unit and memory
interface lsu_axi_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane steering, load extension and alignment check
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [OFF_W-1:0]    off_i,
  input  logic [2:0]          func3_i,
  input  logic                we_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W-1:0]   rdata_i,
  output logic [DATA_W-1:0]   wdata_sh_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic [DATA_W-1:0]   rdata_ext_o,
  output logic                misalign_o
);
  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] lane;
  logic [OFF_W-1:0]  align_mask;
  logic              illegal;

  // Store steering: move LSB-justified data and its byte enables up to the addressed lanes.
  always_comb begin
    wdata_sh_o = wdata_i << {off_i, 3'b000};
    wstrb_o    = STRB_W'(size_mask(func3_i)) << off_i;
  end

  // Load extraction: bring the addressed bytes down to bit 0, then sign/zero-extend.
  always_comb begin
    lane = rdata_i >> {off_i, 3'b000};
    case (func3_i)
      F3_B:    rdata_ext_o = DATA_W'($signed(lane[7:0]));
      F3_H:    rdata_ext_o = DATA_W'($signed(lane[15:0]));
      F3_W:    rdata_ext_o = DATA_W'($signed(lane[31:0]));
      F3_D:    rdata_ext_o = lane;
      F3_BU:   rdata_ext_o = DATA_W'(lane[7:0]);
      F3_HU:   rdata_ext_o = DATA_W'(lane[15:0]);
      F3_WU:   rdata_ext_o = DATA_W'(lane[31:0]);
      default: rdata_ext_o = '0;
    endcase
  end

  // Natural-alignment check; encodings with no legal meaning are folded into misalign.
  always_comb begin
    case (func3_i[1:0])
      2'b00:   align_mask = '0;
      2'b01:   align_mask = OFF_W'(1);
      2'b10:   align_mask = OFF_W'(3);
      default: align_mask = OFF_W'(7);
    endcase
    illegal = 1'b0;
    if (we_i && func3_i[2])
      illegal = 1'b1;
    if (func3_i == 3'b111)
      illegal = 1'b1;
    if ((DATA_W == 32) && ((func3_i == F3_D) || (func3_i == F3_WU)))
      illegal = 1'b1;
    misalign_o = illegal | (|(off_i & align_mask));
  end

endmodule

// File: rtl/lsu_axi_ctrl.sv
// rtl/lsu_axi_ctrl.sv - single-outstanding load/store unit with an AXI-lite master port
module lsu_axi_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_func3,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic              resp_misalign,
  lsu_axi_ctrl_if.master    axi
);
  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          func3_q, func3_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                fault_q, fault_d;
  logic                misalign_q, misalign_d;

  logic                idle;
  logic [OFF_W-1:0]    al_off;
  logic [2:0]          al_func3;
  logic                al_we;
  logic [DATA_W-1:0]   al_wdata_sh;
  logic [DATA_W/8-1:0] al_wstrb;
  logic [DATA_W-1:0]   al_rdata_ext;
  logic                al_misalign;

  assign idle = (state_q == S_IDLE);

  // The aligner looks at the incoming request while idle and at the latched one otherwise.
  always_comb begin
    al_off   = idle ? req_addr[OFF_W-1:0] : addr_q[OFF_W-1:0];
    al_func3 = idle ? req_func3 : func3_q;
    al_we    = idle ? req_we : we_q;
  end

  lsu_lane_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_align (
    .off_i       (al_off),
    .func3_i     (al_func3),
    .we_i        (al_we),
    .wdata_i     (req_wdata),
    .rdata_i     (axi.rdata),
    .wdata_sh_o  (al_wdata_sh),
    .wstrb_o     (al_wstrb),
    .rdata_ext_o (al_rdata_ext),
    .misalign_o  (al_misalign)
  );

  // State and latched-request registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      func3_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      func3_q    <= func3_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rdata_q    <= rdata_d;
      fault_q    <= fault_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state logic: accept, run the AXI phases, then present one response cycle.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    func3_d    = func3_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    rdata_d    = rdata_q;
    fault_d    = fault_q;
    misalign_d = misalign_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          addr_d     = req_addr;
          func3_d    = req_func3;
          wdata_d    = al_wdata_sh;
          wstrb_d    = al_wstrb;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          rdata_d    = '0;
          fault_d    = 1'b0;
          misalign_d = al_misalign;
          if (al_misalign)
            state_d = S_RESP;
          else if (req_we)
            state_d = S_WR;
          else
            state_d = S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        if (axi.arready)
          state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (axi.rvalid) begin
          fault_d = (axi.rresp != AXI_OKAY);
          rdata_d = (axi.rresp != AXI_OKAY) ? '0 : al_rdata_ext;
          state_d = S_RESP;
        end
      end
      S_WR: begin
        if (!aw_done_q && axi.awready)
          aw_done_d = 1'b1;
        if (!w_done_q && axi.wready)
          w_done_d = 1'b1;
        if (aw_done_d && w_done_d)
          state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (axi.bvalid) begin
          fault_d = (axi.bresp != AXI_OKAY);
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake and response outputs are decoded from registered state only.
  always_comb begin
    req_ready     = idle;
    axi.arvalid   = (state_q == S_RD_ADDR);
    axi.rready    = (state_q == S_RD_DATA);
    axi.awvalid   = (state_q == S_WR) && !aw_done_q;
    axi.wvalid    = (state_q == S_WR) && !w_done_q;
    axi.bready    = (state_q == S_WR_RESP);
    axi.araddr    = addr_q;
    axi.awaddr    = addr_q;
    axi.wdata     = wdata_q;
    axi.wstrb     = wstrb_q;
    resp_valid    = (state_q == S_RESP);
    resp_rdata    = (state_q == S_RESP) ? rdata_q : '0;
    resp_fault    = (state_q == S_RESP) && fault_q;
    resp_misalign = (state_q == S_RESP) && misalign_q;
  end

endmodule

// File: tb/tb_lsu_axi_ctrl.sv
// tb/tb_lsu_axi_ctrl.sv - directed self-checking bench for lsu_axi_ctrl
module tb_lsu_axi_ctrl;
  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_func3;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        resp_misalign;

  int errors = 0;
  int checks = 0;

  lsu_axi_ctrl_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  lsu_axi_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_func3     (req_func3),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_fault    (resp_fault),
    .resp_misalign (resp_misalign),
    .axi           (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 0; req_we = 0; req_addr = '0; req_func3 = '0; req_wdata = '0;
    axi.arready = 0; axi.rdata = '0; axi.rresp = '0; axi.rvalid = 0;
    axi.awready = 0; axi.wready = 0; axi.bresp = '0; axi.bvalid = 0;
    step();
    step();
    checks++;
    if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 5'b0)
      begin errors++; $display("FAIL reset_valids: got %b expected 00000",
        {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}); end
    checks++;
    if ({resp_valid, resp_fault, resp_misalign} !== 3'b0 || resp_rdata !== 32'h0)
      begin errors++; $display("FAIL reset_resp: got v/f/m=%b rdata=%h expected 000 and 0",
        {resp_valid, resp_fault, resp_misalign}, resp_rdata); end
    checks++;
    if (req_ready !== 1'b1 || axi.araddr !== 32'h0 || axi.wstrb !== 4'h0)
      begin errors++; $display("FAIL reset_idle: req_ready=%b araddr=%h wstrb=%h expected 1 0 0",
        req_ready, axi.araddr, axi.wstrb); end
    rst = 1'b1;
    step();
  endtask

  task automatic do_load(input string name, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] rd, input logic [1:0] rr,
                         input logic [31:0] exp_rd, input logic exp_fault);
    checks++;
    if (req_ready !== 1'b1)
      begin errors++; $display("FAIL %s_ready: got %b expected 1", name, req_ready); end
    req_valid = 1; req_we = 0; req_addr = addr; req_func3 = f3; req_wdata = '0;
    step();
    req_valid = 0;
    checks++;
    if (axi.arvalid !== 1'b1 || axi.araddr !== addr || req_ready !== 1'b0)
      begin errors++; $display("FAIL %s_ar: arvalid=%b araddr=%h req_ready=%b expected 1 %h 0",
        name, axi.arvalid, axi.araddr, req_ready, addr); end
    axi.arready = 1;
    step();
    axi.arready = 0;
    checks++;
    if (axi.arvalid !== 1'b0 || axi.rready !== 1'b1 || resp_valid !== 1'b0)
      begin errors++; $display("FAIL %s_r: arvalid=%b rready=%b resp_valid=%b expected 0 1 0",
        name, axi.arvalid, axi.rready, resp_valid); end
    axi.rvalid = 1; axi.rdata = rd; axi.rresp = rr;
    step();
    axi.rvalid = 0; axi.rdata = '0; axi.rresp = '0;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== exp_rd || resp_fault !== exp_fault || resp_misalign !== 1'b0)
      begin errors++; $display("FAIL %s_resp: valid=%b rdata=%h fault=%b mis=%b expected 1 %h %b 0",
        name, resp_valid, resp_rdata, resp_fault, resp_misalign, exp_rd, exp_fault); end
    step();
    checks++;
    if (resp_valid !== 1'b0 || resp_fault !== 1'b0 || resp_rdata !== 32'h0 || req_ready !== 1'b1)
      begin errors++; $display("FAIL %s_after: valid=%b fault=%b rdata=%h ready=%b expected 0 0 0 1",
        name, resp_valid, resp_fault, resp_rdata, req_ready); end
  endtask

  task automatic test_loads();
    do_load("lw",  32'h8000_0004, 3'b010, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0);
    do_load("lb",  32'h8000_0003, 3'b000, 32'h80FF_FFFF, 2'b00, 32'hFFFF_FF80, 1'b0);
    do_load("lbu", 32'h8000_0003, 3'b100, 32'h80FF_FFFF, 2'b00, 32'h0000_0080, 1'b0);
    do_load("lh",  32'h8000_0002, 3'b001, 32'h8001_1234, 2'b00, 32'hFFFF_8001, 1'b0);
    do_load("lhu", 32'h8000_0002, 3'b101, 32'h8001_1234, 2'b00, 32'h0000_8001, 1'b0);
    do_load("lb1", 32'h8000_0001, 3'b000, 32'h1122_7F44, 2'b00, 32'h0000_007F, 1'b0);
    do_load("lwerr", 32'h8000_0010, 3'b010, 32'h5555_AAAA, 2'b10, 32'h0000_0000, 1'b1);
  endtask

  task automatic test_store_split();
    req_valid = 1; req_we = 1; req_addr = 32'h8000_0002; req_func3 = 3'b001; req_wdata = 32'h0000_1234;
    step();
    req_valid = 0;
    checks++;
    if (axi.awvalid !== 1'b1 || axi.wvalid !== 1'b1 || axi.awaddr !== 32'h8000_0002)
      begin errors++; $display("FAIL sh_entry: awvalid=%b wvalid=%b awaddr=%h expected 1 1 80000002",
        axi.awvalid, axi.wvalid, axi.awaddr); end
    checks++;
    if (axi.wdata !== 32'h1234_0000 || axi.wstrb !== 4'b1100)
      begin errors++; $display("FAIL sh_lanes: wdata=%h wstrb=%b expected 12340000 1100",
        axi.wdata, axi.wstrb); end
    axi.wready = 1;
    step();
    axi.wready = 0;
    checks++;
    if (axi.wvalid !== 1'b0 || axi.awvalid !== 1'b1 || axi.bready !== 1'b0)
      begin errors++; $display("FAIL sh_w_first: wvalid=%b awvalid=%b bready=%b expected 0 1 0",
        axi.wvalid, axi.awvalid, axi.bready); end
    step();
    checks++;
    if (axi.awvalid !== 1'b1 || axi.bready !== 1'b0 || axi.awaddr !== 32'h8000_0002)
      begin errors++; $display("FAIL sh_aw_hold: awvalid=%b bready=%b awaddr=%h expected 1 0 80000002",
        axi.awvalid, axi.bready, axi.awaddr); end
    axi.awready = 1;
    step();
    axi.awready = 0;
    checks++;
    if (axi.awvalid !== 1'b0 || axi.bready !== 1'b1 || resp_valid !== 1'b0)
      begin errors++; $display("FAIL sh_b: awvalid=%b bready=%b resp_valid=%b expected 0 1 0",
        axi.awvalid, axi.bready, resp_valid); end
    axi.bvalid = 1; axi.bresp = 2'b00;
    step();
    axi.bvalid = 0;
    checks++;
    if (resp_valid !== 1'b1 || resp_fault !== 1'b0 || resp_rdata !== 32'h0 || axi.bready !== 1'b0)
      begin errors++; $display("FAIL sh_resp: valid=%b fault=%b rdata=%h bready=%b expected 1 0 0 0",
        resp_valid, resp_fault, resp_rdata, axi.bready); end
    step();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      begin errors++; $display("FAIL sh_done: valid=%b ready=%b expected 0 1", resp_valid, req_ready); end
  endtask

  task automatic test_store_fault();
    req_valid = 1; req_we = 1; req_addr = 32'h8000_0008; req_func3 = 3'b010; req_wdata = 32'hCAFE_F00D;
    step();
    req_valid = 0;
    checks++;
    if (axi.wdata !== 32'hCAFE_F00D || axi.wstrb !== 4'b1111 || axi.awvalid !== 1'b1 || axi.wvalid !== 1'b1)
      begin errors++; $display("FAIL sw_entry: wdata=%h wstrb=%b aw=%b w=%b expected cafef00d 1111 1 1",
        axi.wdata, axi.wstrb, axi.awvalid, axi.wvalid); end
    axi.awready = 1; axi.wready = 1;
    step();
    axi.awready = 0; axi.wready = 0;
    checks++;
    if (axi.bready !== 1'b1 || axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0)
      begin errors++; $display("FAIL sw_both: bready=%b aw=%b w=%b expected 1 0 0",
        axi.bready, axi.awvalid, axi.wvalid); end
    axi.bvalid = 1; axi.bresp = 2'b10;
    step();
    axi.bvalid = 0; axi.bresp = 2'b00;
    checks++;
    if (resp_valid !== 1'b1 || resp_fault !== 1'b1 || resp_misalign !== 1'b0)
      begin errors++; $display("FAIL sw_fault: valid=%b fault=%b mis=%b expected 1 1 0",
        resp_valid, resp_fault, resp_misalign); end
    step();
    checks++;
    if (resp_fault !== 1'b0 || resp_valid !== 1'b0)
      begin errors++; $display("FAIL sw_fault_clear: fault=%b valid=%b expected 0 0", resp_fault, resp_valid); end
    do_load("post_fault", 32'h8000_000C, 3'b010, 32'h0BAD_F00D, 2'b00, 32'h0BAD_F00D, 1'b0);
  endtask

  task automatic do_misalign(input string name, input logic we, input logic [31:0] addr, input logic [2:0] f3);
    req_valid = 1; req_we = we; req_addr = addr; req_func3 = f3; req_wdata = 32'hFFFF_FFFF;
    step();
    req_valid = 0;
    checks++;
    if (resp_valid !== 1'b1 || resp_misalign !== 1'b1 || resp_fault !== 1'b0 || resp_rdata !== 32'h0)
      begin errors++; $display("FAIL %s_t1: valid=%b mis=%b fault=%b rdata=%h expected 1 1 0 0",
        name, resp_valid, resp_misalign, resp_fault, resp_rdata); end
    checks++;
    if (axi.arvalid !== 1'b0 || axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0)
      begin errors++; $display("FAIL %s_nobus: ar=%b aw=%b w=%b expected 0 0 0",
        name, axi.arvalid, axi.awvalid, axi.wvalid); end
    step();
    checks++;
    if (req_ready !== 1'b1 || resp_misalign !== 1'b0 || resp_valid !== 1'b0 || axi.arvalid !== 1'b0)
      begin errors++; $display("FAIL %s_t2: ready=%b mis=%b valid=%b ar=%b expected 1 0 0 0",
        name, req_ready, resp_misalign, resp_valid, axi.arvalid); end
  endtask

  task automatic test_misalign();
    do_misalign("lw_mis",  1'b0, 32'h8000_0001, 3'b010);
    do_misalign("sh_mis",  1'b1, 32'h8000_0003, 3'b001);
    do_misalign("sd_ill",  1'b1, 32'h8000_0000, 3'b011);
    do_misalign("lwu_ill", 1'b0, 32'h8000_0000, 3'b110);
    do_misalign("sbu_ill", 1'b1, 32'h8000_0000, 3'b100);
  endtask

  task automatic test_reset_mid();
    req_valid = 1; req_we = 0; req_addr = 32'h8000_0020; req_func3 = 3'b010;
    step();
    req_valid = 0;
    checks++;
    if (axi.arvalid !== 1'b1)
      begin errors++; $display("FAIL rstmid_pre: arvalid=%b expected 1", axi.arvalid); end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (axi.arvalid !== 1'b0 || req_ready !== 1'b1)
      begin errors++; $display("FAIL rstmid_async: arvalid=%b ready=%b expected 0 1", axi.arvalid, req_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (resp_valid !== 1'b0 || axi.arvalid !== 1'b0)
        begin errors++; $display("FAIL rstmid_quiet: valid=%b ar=%b expected 0 0", resp_valid, axi.arvalid); end
    end
    rst = 1'b1;
    step();
    do_load("post_rst", 32'h8000_0024, 3'b010, 32'h1357_9BDF, 2'b00, 32'h1357_9BDF, 1'b0);
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store_split();
    test_misalign();
    test_store_fault();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
